outport_alloc: RTL
==================

Name: outport_alloc

Overview:
- Per-output-physical-channel allocator and flow-control responder for the router.
- Answers the input VC controllers' requests (req) with a registered switch grant (grt_N).
- Publishes per-output-VC readiness (irdy) from downstream credit counters and per-output-VC packet locks (ilck).
- One instance per output port, between the five input ports and the crossbar output.

Parameters:
- ROUTERID, 0, router index (debug only)
- PCHID, 0, output port index this instance serves (0..4)
- VCN, 2, number of virtual channels on the output link
- VCW, 1, width of a VC index, ceil(log2(VCN)) with minimum 1
- BUFDEPTH, 4, downstream input-buffer depth per VC (initial credits)
- CNTW, 3, credit counter width; must hold BUFDEPTH

Ports:
- clk  in  1  clock
- rst_  in  1  asynchronous active-low reset
- req_0..req_4  in  1 each  switch request from the input VC currently routed to this output port
- vch_0..vch_4  in  VCW each  output VC requested by input N; sampled only while req_N=1
- grt_0..grt_4  out  1 each  switch grant to input N; at most one high
- xsend  in  1  a flit leaves through this output this cycle
- xtype  in  2  flit type of the outgoing flit (codebase TYPE_* encoding)
- xvch  in  VCW  output VC of the outgoing flit
- cr_valid  in  1  credit return from downstream
- cr_vch  in  VCW  VC of the returned credit
- irdy  out  VCN  irdy[v]=1: downstream VC v has at least one free slot
- ilck  out  VCN  ilck[v]=1: VC v is locked by a packet in flight
- err  out  1  sticky protocol-error flag

Behaviour:
- Reset (asynchronous, rst_=0):
  - all grt_N=0
  - every credit[v]=BUFDEPTH, so irdy all 1
  - every lock[v]=0, so ilck all 0
  - round-robin pointer=0, owner registers=0, err=0
- Outputs:
  - irdy[v] = (credit[v]!=0), combinational from registers.
  - ilck[v] = lock[v], direct register output.
- Grant FSM has two states, IDLE and HOLD.
- IDLE:
  - Input N is eligible when req_N=1 and lock[vch_N]=0.
  - Pick the first eligible input at or after the pointer, wrapping 4 to 0.
  - At the next edge: grt_winner=1, lock[vch_winner]=1, owner=winner, pointer=winner+1 mod 5, go to HOLD.
  - Grant latency is 1 cycle from an eligible req.
  - No eligible input: stay in IDLE, pointer unchanged.
- HOLD:
  - grt_owner stays 1 while req_owner=1, independent of irdy.
  - Edge with req_owner=0: grt_owner=0, go to IDLE.
  - No new grant on that same edge; the next grant comes one cycle later at the earliest.
- Lock release:
  - At an edge with xsend=1 and xtype in {TAIL, HEADTAIL}, lock[xvch] is cleared.
  - This is independent of the grant state.
  - If lock[xvch] was already 0, set err.
- Credits:
  - An edge with xsend=1 decrements credit[xvch].
  - An edge with cr_valid=1 increments credit[cr_vch].
  - Both on the same VC in the same edge: value unchanged.
  - xsend=1 with credit[xvch]=0 (underflow): counter holds, err=1.
  - Increment at BUFDEPTH (overflow): counter holds, err=1.
- xsend while grant state is IDLE sets err.
- err clears only on reset.
- Reset asserted mid-packet returns all state to reset values immediately. No partial lock or credit survives.

Test Plan:
- Single packet:
  - Stimulus: after reset, req_1=1, vch_1=0.
  - Response: grt_1=1 one cycle later and ilck=01.
  - Then send HEAD, BODY, TAIL on xvch=0 with req_1 dropping on the TAIL cycle.
  - Response: credit[0] 4 to 1, irdy[0] stays 1, ilck[0] clears after TAIL, grt_1 drops, state returns to IDLE.
- Round-robin:
  - Stimulus: req_0, req_2, req_4 all held high, vch distinct, each packet one HEADTAIL flit.
  - Response: grant order 0, 2, 4, 0, with one idle cycle between grants.
- Lock blocking:
  - Stimulus: input 0 owns VC1 (tail not yet sent), req_0 dropped; then req_3=1 with vch_3=1.
  - Response: grt_3 stays 0 until the TAIL on VC1 is sent, then grt_3=1 one cycle later.
- Credit exhaustion:
  - Stimulus: 4 BODY sends on VC0 with no returns.
  - Response: irdy[0]=0.
  - Stimulus: a send and a cr_valid on VC0 in the same cycle.
  - Response: credit stays 0.
  - Stimulus: a lone cr_valid on VC0.
  - Response: irdy[0]=1.
- Error cases:
  - Stimulus: cr_valid on a full VC.
  - Response: err=1 and credit stays 4.
  - Stimulus: a TAIL on an unlocked VC.
  - Response: err=1.
  - Stimulus: a send at credit 0.
  - Response: err=1.
- Async reset mid-packet:
  - Stimulus: pulse rst_ low between clock edges while in HOLD.
  - Response: grt all 0, ilck=00, irdy=11, err=0 immediately, without waiting for an edge.

Source files
------------

// File: rtl/outport_alloc_if.sv
// outport_alloc_if: signal bundle between the five input VC controllers /
// crossbar side (master) and one output-port allocator (slave).
//   req_N, vch_N     switch request from input N and the output VC it wants
//   grt_N            registered switch grant back to input N
//   xsend/xtype/xvch flit leaving through this output port this cycle
//   cr_valid/cr_vch  credit returned by the downstream router
//   irdy, ilck       per-output-VC free-slot and packet-lock status
//   err              sticky protocol-error flag
interface outport_alloc_if #(
  parameter int VCN = 2,
  parameter int VCW = 1
);
  logic           req_0, req_1, req_2, req_3, req_4;
  logic [VCW-1:0] vch_0, vch_1, vch_2, vch_3, vch_4;
  logic           grt_0, grt_1, grt_2, grt_3, grt_4;
  logic           xsend;
  logic [1:0]     xtype;
  logic [VCW-1:0] xvch;
  logic           cr_valid;
  logic [VCW-1:0] cr_vch;
  logic [VCN-1:0] irdy;
  logic [VCN-1:0] ilck;
  logic           err;

  modport master (
    output req_0, req_1, req_2, req_3, req_4,
    output vch_0, vch_1, vch_2, vch_3, vch_4,
    output xsend, xtype, xvch, cr_valid, cr_vch,
    input  grt_0, grt_1, grt_2, grt_3, grt_4,
    input  irdy, ilck, err
  );

  modport slave (
    input  req_0, req_1, req_2, req_3, req_4,
    input  vch_0, vch_1, vch_2, vch_3, vch_4,
    input  xsend, xtype, xvch, cr_valid, cr_vch,
    output grt_0, grt_1, grt_2, grt_3, grt_4,
    output irdy, ilck, err
  );
endinterface

// File: rtl/outport_alloc.sv
// outport_alloc: switch allocator and flow-control tracker for one router
// output port. Grants the crossbar output to one of five inputs in
// round-robin order, locks the chosen output VC until its tail flit leaves,
// and tracks downstream buffer credits per output VC.
// Ports:
//   clk   clock
//   rst_  asynchronous active-low reset
//   bus   slave side of outport_alloc_if (requests/grants, outgoing flit,
//         credit return, irdy/ilck status, sticky err)
//
// state | meaning
// IDLE  | no input owns the output; arbitrate among eligible requests
// HOLD  | owner input holds the crossbar output until it drops req
module outport_alloc #(
  parameter int ROUTERID = 0,
  parameter int PCHID    = 0,
  parameter int VCN      = 2,
  parameter int VCW      = 1,
  parameter int BUFDEPTH = 4,
  parameter int CNTW     = 3
) (
  input logic            clk,
  input logic            rst_,
  outport_alloc_if.slave bus
);
  localparam int NIN = 5;
  localparam logic [1:0] TYPE_TAIL     = 2'b10;
  localparam logic [1:0] TYPE_HEADTAIL = 2'b11;

  if (PCHID < 0 || PCHID >= NIN) begin : g_bad_pchid
    $error("outport_alloc: PCHID out of range");
  end
  if (ROUTERID < 0) begin : g_bad_routerid
    $error("outport_alloc: ROUTERID must be non-negative");
  end
  if (BUFDEPTH >= (1 << CNTW)) begin : g_bad_cntw
    $error("outport_alloc: CNTW too narrow for BUFDEPTH");
  end
  if ((1 << VCW) < VCN) begin : g_bad_vcw
    $error("outport_alloc: VCW too narrow for VCN");
  end

  typedef enum logic {IDLE, HOLD} state_t;

  state_t          state_q, state_d;
  logic [NIN-1:0]  grt_q, grt_d;
  logic [VCN-1:0]  lock_q, lock_d;
  logic [CNTW-1:0] credit_q [VCN];
  logic [CNTW-1:0] credit_d [VCN];
  logic [2:0]      ptr_q, ptr_d;
  logic [2:0]      owner_q, owner_d;
  logic            err_q, err_d;

  logic [NIN-1:0]  req;
  logic [VCW-1:0]  vch [NIN];
  logic [NIN-1:0]  elig;
  logic            pick_vld;
  logic [2:0]      pick;
  logic [VCN-1:0]  irdy;

  assign req    = {bus.req_4, bus.req_3, bus.req_2, bus.req_1, bus.req_0};
  assign vch[0] = bus.vch_0;
  assign vch[1] = bus.vch_1;
  assign vch[2] = bus.vch_2;
  assign vch[3] = bus.vch_3;
  assign vch[4] = bus.vch_4;

  // Round-robin search: first eligible input at or after ptr_q, wrapping.
  always_comb begin
    logic [3:0] idx;
    idx      = '0;
    elig     = '0;
    pick_vld = 1'b0;
    pick     = '0;
    for (int i = 0; i < NIN; i++) elig[i] = req[i] & ~lock_q[vch[i]];
    for (int k = 0; k < NIN; k++) begin
      idx = {1'b0, ptr_q} + 4'(k);
      if (idx >= 4'(NIN)) idx = idx - 4'(NIN);
      if (!pick_vld && elig[idx]) begin
        pick_vld = 1'b1;
        pick     = 3'(idx);
      end
    end
  end

  always_comb begin
    logic inc;
    logic dec;
    inc      = 1'b0;
    dec      = 1'b0;
    state_d  = state_q;
    grt_d    = grt_q;
    lock_d   = lock_q;
    ptr_d    = ptr_q;
    owner_d  = owner_q;
    err_d    = err_q;
    credit_d = credit_q;

    // Tail release is evaluated before a new grant so a grant on the same
    // edge always leaves its VC locked.
    if (bus.xsend && (bus.xtype == TYPE_TAIL || bus.xtype == TYPE_HEADTAIL)) begin
      if (!lock_q[bus.xvch]) err_d = 1'b1;
      lock_d[bus.xvch] = 1'b0;
    end
    if (bus.xsend && state_q == IDLE) err_d = 1'b1;

    unique case (state_q)
      IDLE: begin
        if (pick_vld) begin
          grt_d             = NIN'(1) << pick;
          lock_d[vch[pick]] = 1'b1;
          owner_d           = pick;
          ptr_d             = (pick == 3'(NIN - 1)) ? 3'd0 : pick + 3'd1;
          state_d           = HOLD;
        end
      end
      HOLD: begin
        // Releasing the output costs a cycle: no re-arbitration on this edge.
        if (!req[owner_q]) begin
          grt_d   = '0;
          state_d = IDLE;
        end
      end
      default: ;
    endcase

    // A send and a return on the same VC cancel out, so neither can
    // under- or overflow the counter.
    for (int v = 0; v < VCN; v++) begin
      inc = bus.cr_valid && (bus.cr_vch == VCW'(v));
      dec = bus.xsend && (bus.xvch == VCW'(v));
      if (inc && !dec) begin
        if (credit_q[v] == CNTW'(BUFDEPTH)) err_d = 1'b1;
        else credit_d[v] = credit_q[v] + CNTW'(1);
      end else if (dec && !inc) begin
        if (credit_q[v] == '0) err_d = 1'b1;
        else credit_d[v] = credit_q[v] - CNTW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      state_q <= IDLE;
      grt_q   <= '0;
      lock_q  <= '0;
      ptr_q   <= '0;
      owner_q <= '0;
      err_q   <= 1'b0;
      for (int v = 0; v < VCN; v++) credit_q[v] <= CNTW'(BUFDEPTH);
    end else begin
      state_q  <= state_d;
      grt_q    <= grt_d;
      lock_q   <= lock_d;
      ptr_q    <= ptr_d;
      owner_q  <= owner_d;
      err_q    <= err_d;
      credit_q <= credit_d;
    end
  end

  always_comb begin
    irdy = '0;
    for (int v = 0; v < VCN; v++) irdy[v] = (credit_q[v] != '0);
  end

  assign bus.irdy  = irdy;
  assign bus.ilck  = lock_q;
  assign bus.err   = err_q;
  assign bus.grt_0 = grt_q[0];
  assign bus.grt_1 = grt_q[1];
  assign bus.grt_2 = grt_q[2];
  assign bus.grt_3 = grt_q[3];
  assign bus.grt_4 = grt_q[4];
endmodule
